// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: fetch/decode/execute/memory/writeback sequencing with a
// mem_ready wait-state handshake and optional timeout. Define BNE_EN to add bne to the branch state.
module multicycle_control_unit #(
    parameter int unsigned ALU_CTRL_W  = 3,
    parameter int unsigned TIMEOUT_W   = 8,
    parameter int unsigned TIMEOUT_MAX = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            op,
    input  logic [2:0]            funct3,
    input  logic                  funct7b5,
    input  logic                  Zero,
    input  logic                  mem_ready,
    output logic                  PCWrite,
    output logic                  AdrSrc,
    output logic                  MemWrite,
    output logic                  IRWrite,
    output logic                  RegWrite,
    output logic [1:0]            ResultSrc,
    output logic [1:0]            ALUSrcA,
    output logic [1:0]            ALUSrcB,
    output logic [1:0]            ImmSrc,
    output logic [ALU_CTRL_W-1:0] ALUControl,
    output logic                  instr_done,
    output logic                  illegal_instr,
    output logic                  mem_timeout
);

    typedef enum logic [3:0] {
        StFetch, StDecode, StMemAdr, StMemRead, StMemWb, StMemWrite,
        StExecR, StExecI, StJal, StAluWb, StBeq
    } state_e;

    localparam bit                   TimeoutEn = (TIMEOUT_MAX > 0);
    localparam logic [TIMEOUT_W-1:0] WaitLast  = TIMEOUT_W'(TIMEOUT_MAX - 1);

    state_e               state_q, state_d;
    logic [TIMEOUT_W-1:0] wait_cnt_q, wait_cnt_d;

    logic       is_wait_state;
    logic       timeout;
    logic [1:0] alu_op;
    logic [2:0] alu_ctrl;
    logic       pc_write, mem_write, ir_write, reg_write, done, illegal;

    assign is_wait_state = (state_q inside {StFetch, StMemRead, StMemWrite});
    // mem_ready wins over an expiring counter in the same cycle.
    assign timeout = TimeoutEn && is_wait_state && !mem_ready && (wait_cnt_q == WaitLast);

    always_comb begin
        state_d   = state_q;
        pc_write  = 1'b0;
        mem_write = 1'b0;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        done      = 1'b0;
        illegal   = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        alu_op    = 2'b00;
        unique case (state_q)
            StFetch: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) state_d = StDecode;
            end
            StDecode: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                unique case (op)
                    7'b0000011, 7'b0100011: state_d = StMemAdr;
                    7'b0110011:             state_d = StExecR;
                    7'b0010011:             state_d = StExecI;
                    7'b1101111:             state_d = StJal;
                    7'b1100011:             state_d = StBeq;
                    default: begin
                        state_d = StFetch;
                        illegal = 1'b1;
                    end
                endcase
            end
            StMemAdr: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = op[5] ? StMemWrite : StMemRead;
            end
            StMemRead: begin
                AdrSrc = 1'b1;
                if (mem_ready)    state_d = StMemWb;
                else if (timeout) state_d = StFetch;
            end
            StMemWb: begin
                ResultSrc = 2'b01;
                reg_write = 1'b1;
                done      = 1'b1;
                state_d   = StFetch;
            end
            StMemWrite: begin
                AdrSrc    = 1'b1;
                mem_write = !timeout;
                if (mem_ready) begin
                    done    = 1'b1;
                    state_d = StFetch;
                end else if (timeout) begin
                    state_d = StFetch;
                end
            end
            StExecR: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b10;
                state_d = StAluWb;
            end
            StExecI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = 2'b10;
                state_d = StAluWb;
            end
            StJal: begin
                ALUSrcA  = 2'b01;
                ALUSrcB  = 2'b10;
                pc_write = 1'b1;
                state_d  = StAluWb;
            end
            StAluWb: begin
                reg_write = 1'b1;
                done      = 1'b1;
                state_d   = StFetch;
            end
            StBeq: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b01;
`ifdef BNE_EN
                pc_write = (funct3 == 3'b001) ? ~Zero : Zero;
`else
                pc_write = Zero;
`endif
                done     = 1'b1;
                state_d  = StFetch;
            end
            default: state_d = StFetch;
        endcase
        if (timeout) state_d = StFetch;
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_d != state_q || timeout) begin
            wait_cnt_d = '0;
        end else if (is_wait_state && !mem_ready && wait_cnt_q != '1) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    always_comb begin
        alu_ctrl = 3'b000;
        unique case (alu_op)
            2'b01: alu_ctrl = 3'b001;
            2'b10: begin
                unique case (funct3)
                    3'b000:  alu_ctrl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  alu_ctrl = 3'b101;
                    3'b110:  alu_ctrl = 3'b011;
                    3'b111:  alu_ctrl = 3'b010;
                    default: alu_ctrl = 3'b000;
                endcase
            end
            default: alu_ctrl = 3'b000;
        endcase
    end

    always_comb begin
        unique case (op)
            7'b0100011: ImmSrc = 2'b01;
            7'b1100011: ImmSrc = 2'b10;
            7'b1101111: ImmSrc = 2'b11;
            default:    ImmSrc = 2'b00;
        endcase
    end

    assign ALUControl    = ALU_CTRL_W'(alu_ctrl);
    assign PCWrite       = pc_write & ~rst;
    assign MemWrite      = mem_write & ~rst;
    assign IRWrite       = ir_write & ~rst;
    assign RegWrite      = reg_write & ~rst;
    assign instr_done    = done & ~rst;
    assign illegal_instr = illegal & ~rst;
    assign mem_timeout   = timeout & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StFetch;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Next-generation control unit for the multi-cycle RISC-V datapath. It replaces the purely combinational single-cycle decode with a state machine that sequences fetch, decode, execute, memory and writeback over several clocks.
- Memory accesses use a `mem_ready` wait-state handshake, guarded by a parametrised timeout.
- Decodes RV32I subset: lw, sw, R-type, I-type ALU, jal, beq (bne optional).

Parameters:
- ALU_CTRL_W, 3, ALUControl width. Codes 000 add, 001 sub, 010 and, 011 or, 101 slt; upper bits zero when wider.
- TIMEOUT_W, 8, width of the memory wait-cycle counter.
- TIMEOUT_MAX, 0, wait cycles before abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- op  in  7  instruction opcode
- funct3  in  3  instruction funct3
- funct7b5  in  1  instruction bit 30
- Zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current access this cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0 PC, 1 ALUOut
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction/OldPC register enable
- RegWrite  out  1  register file write
- ResultSrc  out  2  result select: 00 ALUOut, 01 Data, 10 ALUResult
- ALUSrcA  out  2  ALU A select: 00 PC, 01 OldPC, 10 rs1
- ALUSrcB  out  2  ALU B select: 00 rs2, 01 Imm, 10 constant 4
- ImmSrc  out  2  immediate format: 00 I, 01 S, 10 B, 11 J
- ALUControl  out  ALU_CTRL_W  ALU operation
- instr_done  out  1  one-cycle pulse when an instruction retires
- illegal_instr  out  1  one-cycle pulse on undecodable opcode
- mem_timeout  out  1  one-cycle pulse on memory wait abort

Behaviour:
- Registered state, 4 bits; all other outputs are combinational from state and inputs.
- Reset: state=FETCH. While rst=1, PCWrite, IRWrite, RegWrite, MemWrite, instr_done, illegal_instr and mem_timeout are forced 0. Wait counter is cleared. Reset mid-instruction abandons it with no write.
- Unlisted outputs in a state default to 0 (ALUOp defaults to 00).
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10; IRWrite=PCWrite=mem_ready. On mem_ready, go to DECODE; otherwise stay.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1101111 -> JAL
  - 1100011 -> BEQ
  - else -> FETCH with illegal_instr=1
- MEMADR: ALUSrcA=10, ALUSrcB=01. Go to MEMREAD if op[5]=0, else MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Go to MEMWB on mem_ready.
- MEMWB: ResultSrc=01, RegWrite=1, instr_done=1; then FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1, held until mem_ready. On mem_ready: instr_done=1, then FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10; then ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10; then ALUWB.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1; then ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, instr_done=1; then FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=Zero, instr_done=1; then FETCH.
- ALU decode:
  - ALUOp 00 -> add; ALUOp 01 -> sub.
  - ALUOp 10 by funct3: 000 -> sub if op[5]&funct7b5, else add; 010 -> slt; 110 -> or; 111 -> and; others -> add.
- ImmSrc from op, combinational in every state: store 01, branch 10, jal 11, else 00.
- Timeout:
  - Counter increments each cycle in FETCH, MEMREAD or MEMWRITE while mem_ready=0, and clears on any state change.
  - If TIMEOUT_MAX>0 and counter==TIMEOUT_MAX-1 with mem_ready=0: mem_timeout=1, all write enables 0 that cycle, next state FETCH.
  - The counter saturates and never wraps.
  - mem_ready takes priority over timeout in the same cycle.

Optional Feature:
- BNE_EN defined: in BEQ state, funct3=001 gives PCWrite=~Zero; funct3=000 gives PCWrite=Zero.
- BNE_EN undefined: PCWrite=Zero regardless of funct3.

Test Plan:
- Reset, rst=1 for 3 cycles with mem_ready=1 -> all write enables 0. First rst deassert edge -> FETCH; IRWrite=PCWrite=1.
- add (op=0110011, funct3=000, funct7b5=0), mem_ready=1 -> FETCH, DECODE, EXECUTER (ALUControl=000), ALUWB (RegWrite=1, instr_done=1). 4 cycles total.
- lw with mem_ready low 3 cycles in MEMREAD -> MEMREAD held 4 cycles; MEMWB RegWrite=1, ResultSrc=01. sw -> MemWrite held high until mem_ready.
- beq with Zero=1 -> PCWrite=1 in BEQ. Zero=0 -> PCWrite=0. With BNE_EN and funct3=001, Zero=0 -> PCWrite=1.
- op=1111111 -> DECODE then FETCH; illegal_instr pulses once; no RegWrite or MemWrite.
- TIMEOUT_MAX=4, mem_ready=0 in MEMREAD -> mem_timeout at 4th wait cycle, then FETCH, RegWrite never asserted.
